// File: rtl/riscv_defines.sv
// Shared core definitions: store buffer entry layout and default depth.
package riscv_defines;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  localparam int SB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/store_buffer_lookup.sv
// Combinational load search: per byte lane, the youngest valid matching entry
// with that byte enabled supplies the data.
module store_buffer_lookup
  import riscv_defines::*;
#(
  parameter  int DEPTH = SB_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [AW-1:0]         head,
  input  logic [31:0]           ld_addr,
  input  logic [3:0]            ld_be,
  output logic [3:0]            coverage,
  output logic [31:0]           data
);

  logic [AW-1:0] idx;
  logic [1:0]    unused_ld_lsb;
  assign unused_ld_lsb = ld_addr[1:0];

  // Walk oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    coverage = '0;
    data     = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (valid[idx] && entries[idx].waddr == ld_addr[31:2]) begin
        for (int i = 0; i < 4; i++) begin
          if (ld_be[i] && entries[idx].be[i]) begin
            coverage[i]     = 1'b1;
            data[8*i +: 8]  = entries[idx].data[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit in-order store buffer: FIFO of committed stores draining to
// memory over valid/ready, with byte-accurate load forwarding.
module store_buffer
  import riscv_defines::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_be,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_be,
  input  logic        mem_req_ready,
  output logic        drained
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            head, tail, count;
  sb_entry_t [DEPTH-1:0]  entries;
  logic [DEPTH-1:0]       valid;
  logic                   empty, full, enq, deq;
  logic [3:0]             coverage;
  logic [31:0]            fwd_data;
  sb_entry_t              hd;
  logic [1:0]             unused_st_lsb;

  assign unused_st_lsb = st_addr[1:0];

  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign count = tail - head;
  assign enq   = st_valid && !full;
  assign deq   = !empty && mem_req_ready;

  // An entry is live when its distance from head is below the occupancy.
  for (genvar j = 0; j < DEPTH; j++) begin : g_valid
    logic [AW-1:0] offset;
    assign offset   = AW'(j) - head[AW-1:0];
    assign valid[j] = ({1'b0, offset} < count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
    end
  end

  // Storage needs no reset: liveness comes entirely from the pointers.
  always_ff @(posedge clk) begin
    if (enq) entries[tail[AW-1:0]] <= '{waddr: st_addr[31:2], data: st_data, be: st_be};
  end

  assign hd            = entries[head[AW-1:0]];
  assign mem_req_valid = !empty;
  assign mem_req_addr  = empty ? '0 : {hd.waddr, 2'b00};
  assign mem_req_data  = empty ? '0 : hd.data;
  assign mem_req_be    = empty ? '0 : hd.be;
  assign st_ready      = !full;
  assign drained       = empty;

  store_buffer_lookup #(.DEPTH(DEPTH)) u_lookup (
    .entries  (entries),
    .valid    (valid),
    .head     (head[AW-1:0]),
    .ld_addr  (ld_addr),
    .ld_be    (ld_be),
    .coverage (coverage),
    .data     (fwd_data)
  );

  assign ld_hit   = ld_valid && (coverage == ld_be) && (ld_be != 4'b0);
  assign ld_stall = ld_valid && (coverage != 4'b0) && (coverage != ld_be);
  assign ld_data  = ld_valid ? fwd_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
  import riscv_defines::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_be = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready = 1'b0;
  logic        drained;

  int checks = 0;
  int errors = 0;
  sb_entry_t q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready), .drained(drained)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n) assert (!(st_valid && ld_valid)) else $error("FAIL st_valid and ld_valid overlap");

  // Reference: every requested byte takes the youngest queued store covering it.
  function automatic void exp_load(input logic v, input logic [31:0] a, input logic [3:0] be,
                                   output logic hit, output logic stall, output logic [31:0] d);
    logic [3:0] cov;
    cov = '0;
    d   = '0;
    if (v)
      foreach (q[k])
        if (q[k].waddr == a[31:2])
          for (int i = 0; i < 4; i++)
            if (be[i] && q[k].be[i]) begin
              cov[i] = 1'b1;
              d[8*i +: 8] = q[k].data[8*i +: 8];
            end
    hit   = v && cov == be && be != 4'b0;
    stall = v && cov != 4'b0 && cov != be;
  endfunction

  // Advance one clock, updating the model by the handshake rules.
  task automatic tick();
    bit acc, dq;
    acc = st_valid && q.size() < DEPTH;
    dq  = q.size() != 0 && mem_req_ready;
    @(posedge clk);
    if (dq) void'(q.pop_front());
    if (acc) q.push_back('{waddr: st_addr[31:2], data: st_data, be: st_be});
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    mem_req_ready = 1'b1;
    n = 0;
    while (!drained && n < 20) begin tick(); n++; end
    mem_req_ready = 1'b0;
    checks++;
    if (!drained) begin errors++; $display("FAIL drain_timeout drained=%0b want 1", drained); end
    q.delete();
  endtask

  task automatic test_reset();
    ld_valid = 1'b1; ld_addr = 32'h100; ld_be = 4'hF;
    #3;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready got %0b want 1", st_ready); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL rst_drained got %0b want 1", drained); end
    checks++; if ({mem_req_valid, mem_req_addr, mem_req_data, mem_req_be} !== 69'b0) begin
      errors++; $display("FAIL rst_mem_req got v=%0b a=%h d=%h be=%h want 0", mem_req_valid, mem_req_addr, mem_req_data, mem_req_be); end
    checks++; if ({ld_hit, ld_stall, ld_data} !== 34'b0) begin
      errors++; $display("FAIL rst_load got hit=%0b stall=%0b data=%h want 0", ld_hit, ld_stall, ld_data); end
    ld_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    mem_req_ready = 1'b0;
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_be = 4'hF;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_latency mem_req_valid=%0b want 0", mem_req_valid); end
    tick(); st_valid = 1'b0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_head v=%0b a=%h d=%h want 1 100 deadbeef", mem_req_valid, mem_req_addr, mem_req_data); end
    ld_valid = 1'b1; ld_addr = 32'h102; ld_be = 4'hF; #1;
    checks++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_load hit=%0b stall=%0b data=%h want 1 0 deadbeef", ld_hit, ld_stall, ld_data); end
    ld_valid = 1'b0;
    drain_all();
  endtask

  task automatic test_partial();
    logic eh, es; logic [31:0] ed;
    int n;
    store(32'h200, 32'h11, 4'b0001);
    store(32'h200, 32'h2200, 4'b0010);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'b0011; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h00002211) begin
      errors++; $display("FAIL partial_hit hit=%0b data=%h want 1 00002211", ld_hit, ld_data); end
    ld_be = 4'b0111; #1;
    checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin
      errors++; $display("FAIL partial_stall stall=%0b hit=%0b want 1 0", ld_stall, ld_hit); end
    mem_req_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 8) begin
      #1; exp_load(ld_valid, ld_addr, ld_be, eh, es, ed);
      checks++; if (ld_stall !== es || ld_hit !== eh || ld_data !== ed) begin
        errors++; $display("FAIL partial_drain stall=%0b hit=%0b data=%h want %0b %0b %h", ld_stall, ld_hit, ld_data, es, eh, ed); end
      tick(); n++;
    end
    #1;
    checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || drained !== 1'b1) begin
      errors++; $display("FAIL partial_miss hit=%0b stall=%0b drained=%0b want 0 0 1", ld_hit, ld_stall, drained); end
    ld_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic test_youngest();
    store(32'h300, 32'hAAAAAAAA, 4'hF);
    store(32'h300, 32'hBBBBBBBB, 4'hF);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_be = 4'hF; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hBBBBBBBB) begin
      errors++; $display("FAIL youngest hit=%0b data=%h want 1 bbbbbbbb", ld_hit, ld_data); end
    ld_valid = 1'b0;
    drain_all();
  endtask

  task automatic test_full_wrap();
    int n;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) store(32'h400 + 32'(4*k), $urandom, 4'hF);
    st_valid = 1'b1; st_addr = 32'h410; st_data = 32'h5; st_be = 4'hF; #1;
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", st_ready); end
    tick(); st_valid = 1'b0;
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0; #1;
    checks++; if (st_ready !== 1'b1 || mem_req_addr !== 32'h404) begin
      errors++; $display("FAIL full_deq ready=%0b addr=%h want 1 404", st_ready, mem_req_addr); end
    store(32'h420, 32'h6, 4'hF);
    st_valid = 1'b1; st_addr = 32'h424; st_data = 32'h7; st_be = 4'hF; mem_req_ready = 1'b1; #1;
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL nobypass ready=%0b want 0", st_ready); end
    tick(); #1;
    checks++; if (st_ready !== 1'b1 || mem_req_addr !== 32'h408) begin
      errors++; $display("FAIL deq_only ready=%0b addr=%h want 1 408", st_ready, mem_req_addr); end
    for (int k = 0; k < 6; k++) begin
      st_addr = 32'h430 + 32'(4*k); st_data = $urandom; #1;
      checks++; if (st_ready !== 1'b1 || mem_req_addr !== {q[0].waddr, 2'b00}) begin
        errors++; $display("FAIL wrap_steady ready=%0b addr=%h want 1 %h", st_ready, mem_req_addr, {q[0].waddr, 2'b00}); end
      tick();
    end
    st_valid = 1'b0;
    n = 0;
    while (!drained && n < 10) begin tick(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL wrap_count drained after %0d want 3", n); end
    mem_req_ready = 1'b0; q.delete();
  endtask

  task automatic test_random();
    logic eh, es; logic [31:0] ed;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 2);
      st_valid = (r == 0); ld_valid = (r == 1);
      st_addr = 32'h500 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      st_data = $urandom; st_be = 4'($urandom_range(0, 15));
      ld_addr = 32'h500 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      ld_be = 4'($urandom_range(0, 15));
      mem_req_ready = ($urandom_range(0, 3) == 0);
      #1;
      exp_load(ld_valid, ld_addr, ld_be, eh, es, ed);
      checks++; if (ld_hit !== eh || ld_stall !== es || ld_data !== ed) begin
        errors++; $display("FAIL rnd_load hit=%0b stall=%0b data=%h want %0b %0b %h", ld_hit, ld_stall, ld_data, eh, es, ed); end
      checks++;
      if (q.size() == 0) begin
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || drained !== 1'b1 || st_ready !== 1'b1) begin
          errors++; $display("FAIL rnd_empty v=%0b a=%h drained=%0b ready=%0b", mem_req_valid, mem_req_addr, drained, st_ready); end
      end else if (mem_req_valid !== 1'b1 || mem_req_addr !== {q[0].waddr, 2'b00} || mem_req_data !== q[0].data ||
                   mem_req_be !== q[0].be || drained !== 1'b0 || st_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_head a=%h d=%h be=%h ready=%0b want %h %h %h %0b", mem_req_addr, mem_req_data,
                           mem_req_be, st_ready, {q[0].waddr, 2'b00}, q[0].data, q[0].be, q.size() < DEPTH);
      end
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    drain_all();
  endtask

  task automatic test_async_reset();
    mem_req_ready = 1'b0;
    store(32'h600, 32'h1, 4'hF);
    store(32'h604, 32'h2, 4'hF);
    store(32'h608, 32'h3, 4'hF);
    #2; rst_n = 1'b0; #1;
    q.delete();
    checks++; if (drained !== 1'b1 || mem_req_valid !== 1'b0 || st_ready !== 1'b1) begin
      errors++; $display("FAIL async_rst drained=%0b v=%0b ready=%0b want 1 0 1", drained, mem_req_valid, st_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_addr = 32'h600 + 32'(4*k); ld_be = 4'hF; #1;
      checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0) begin
        errors++; $display("FAIL rst_discard hit=%0b stall=%0b data=%h want 0 0 0", ld_hit, ld_stall, ld_data); end
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_youngest();
    test_full_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the MEM stage and data memory. Stores leave the pipeline into a small in-order FIFO, and the FIFO drains them to memory over a valid/ready handshake. Later loads search the FIFO: a load whose bytes are all held there is served from the FIFO, a partially covered load stalls, and any other load goes to memory. This is the load-side counterpart of store-data forwarding in the pipeline.

## Interface
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  MEM stage commits a store (memaccess_m == MEM_WRITE).
- st_addr  in  32  store byte address; bits [1:0] ignored.
- st_data  in  32  store data, already placed in byte lanes.
- st_be  in  4  byte enables.
- st_ready  out  1  high when the buffer is not full; a store is accepted only when st_valid && st_ready.
- ld_valid  in  1  MEM stage performs a load (MEM_READ).
- ld_addr  in  32  load byte address; bits [1:0] ignored.
- ld_be  in  4  requested bytes.
- ld_hit  out  1  every requested byte is supplied by the buffer.
- ld_data  out  32  forwarded data; 0 in lanes that are not hit.
- ld_stall  out  1  partial coverage; the pipeline holds the load.
- mem_req_valid  out  1  head entry valid.
- mem_req_addr  out  32  head address, as {addr[31:2], 2'b00}.
- mem_req_data  out  32  head data.
- mem_req_be  out  4  head byte enables.
- mem_req_ready  in  1  memory accepts the head entry.
- drained  out  1  buffer is empty (used by fence and fence.i).

## Operation
- Circular FIFO with head and tail pointers of width log2(DEPTH)+1. The MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Enqueue: on st_valid && !full, the entry {st_addr[31:2], st_data, st_be} is written at the tail, and the tail advances.
- Dequeue: on mem_req_valid && mem_req_ready, the head advances. The handshake outputs come straight from the head entry, so they hold stable while ready is low.
- Simultaneous enqueue and dequeue: both happen and the count is unchanged. When full, st_ready = 0 even if a dequeue happens in the same cycle (no bypass).
- Load search is combinational over all valid entries, including an entry being dequeued this cycle. A word matches when entry.addr == ld_addr[31:2].
  - For each lane i with ld_be[i] set, the youngest matching entry with be[i] set supplies byte i.
  - Coverage = the set of requested lanes that have a supplier.
  - ld_hit = ld_valid && coverage == ld_be && ld_be != 0.
  - ld_stall = ld_valid && coverage != 0 && coverage != ld_be.
  - ld_hit and ld_stall are never both high.
- If ld_valid = 0, then ld_hit = ld_stall = 0 and ld_data = 0.
- st_valid and ld_valid in the same cycle is illegal (single memory port in MEM). The bench asserts this never occurs.
- Stalled load: it re-evaluates every cycle. It resolves to a hit or a miss once the overlapping entries drain.
- drained = empty; it depends only on state.

## Timing
- Reset (async assert): head = tail = 0 and all entries invalid. Outputs:
  - st_ready = 1, drained = 1.
  - mem_req_valid = 0, mem_req_* = 0.
  - ld_hit = ld_stall = 0, ld_data = 0.
- Reset released mid-drain: all pending stores are discarded.
- An enqueued store appears on mem_req_valid at the earliest in the next cycle (minimum latency 1) and becomes searchable in the same cycle.
- A dequeued entry no longer participates in search from the next cycle.
- Load lookup: 0-cycle combinational path from ld_addr/ld_be to ld_hit, ld_stall and ld_data.
- Throughput: one enqueue and one dequeue per cycle.

## Structure
- The shared package riscv_defines gains sb_entry_t = struct {logic [29:0] waddr; logic [31:0] data; logic [3:0] be;}, plus the constant SB_DEPTH_DEFAULT = 4.
- One sub-module, store_buffer_lookup: a combinational youngest-match priority search per byte lane. Its inputs are the entry array, valid mask, head pointer, ld_addr and ld_be. Its outputs are coverage and data.
- The top level holds the pointers, storage and handshake logic.

## Test plan
- Reset, then one store of 0xDEADBEEF to 0x100 with be=1111 while mem_req_ready=0. Then mem_req_valid=1 with addr 0x100, and a load of 0x100 with be=1111 gives ld_hit=1, ld_data=0xDEADBEEF.
- Store 0x11 (be=0001) and then 0x2200 (be=0010) to 0x200. A load of be=0011 gives ld_hit=1, ld_data=0x00002211. A load of be=0111 gives ld_stall=1 until both entries drain, then a miss (hit=0, stall=0).
- Two stores to 0x300: 0xAAAAAAAA, then 0xBBBBBBBB. A load with be=1111 returns 0xBBBBBBBB (youngest wins).
- Fill 4 entries with ready=0: st_ready=0 and a fifth st_valid is not accepted. Set ready=1 for one cycle: the count drops to 3, st_ready=1, and the head address matches the second store.
- Full buffer with st_valid and mem_req_ready both high: a dequeue only, count goes to 3. Then with count 3, an enqueue and dequeue together keep the count at 3 across wrap-around of the pointers.
- Assert rst_n low with 3 entries pending: drained=1 and mem_req_valid=0 immediately (asynchronously), and a load of any previously stored address misses.
